// File: rtl/bioee_vector_player_if.sv
// Host word pipe into the vector player: valid/ready handshake.
// Ports: in_valid, in_data (IN_W), in_ready; master = host, slave = player.
interface bioee_vector_player_if #(
    parameter int IN_W = 32
);
    logic            in_valid;
    logic [IN_W-1:0] in_data;
    logic            in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/bioee_vector_player.sv
// Vector player: splits host words into OUT_W vectors, buffers them and
// plays them out at rate+1 clocks per vector in stream or loop mode.
// Ports: vectorclk, vectorreset (async, active high), host (slave modport:
// in_valid/in_data/in_ready), clear, start, stop, loop_mode, rate,
// vector_out, vector_strobe, busy, level, underflow.
// Optional macro BIOEE_VECTOR_PROG_FULL_EN adds prog_full_thresh/prog_full.
module bioee_vector_player #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int DIV_W      = 16
) (
    input  logic                    vectorclk,
    input  logic                    vectorreset,
    bioee_vector_player_if.slave    host,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_mode,
    input  logic [DIV_W-1:0]        rate,
    output logic [OUT_W-1:0]        vector_out,
    output logic                    vector_strobe,
    output logic                    busy,
    output logic [DEPTH_LOG2:0]     level,
    output logic                    underflow
`ifdef BIOEE_VECTOR_PROG_FULL_EN
    ,
    input  logic [DEPTH_LOG2:0]     prog_full_thresh,
    output logic                    prog_full
`endif
);
    localparam int RATIO = IN_W / OUT_W;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   lvl_t;
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] mem [DEPTH];
    ptr_t             wr_ptr, rd_ptr, idx, rd_addr;
    logic [DIV_W-1:0] div_q, rate_q;
    logic             loop_q;
    logic             start_ok, loop_rej, tick;
    logic             wr, pop, emit, uf_set;
    lvl_t             free;

    assign free          = lvl_t'(DEPTH) - level;
    assign host.in_ready = (free >= lvl_t'(RATIO)) &&
                           !((state_q == RUN) && loop_q);
    assign busy          = (state_q == RUN);

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        loop_rej = 1'b0;
        tick     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // stop beats start; loop playback needs a pattern
                if (start && !stop) begin
                    if (loop_mode && level == '0) begin
                        loop_rej = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                // a tick in the stop cycle would strobe after stop
                if (stop) state_d = IDLE;
                else      tick    = (div_q == rate_q);
            end
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    // an incoming word never satisfies a tick in the same cycle
    assign wr      = host.in_valid && host.in_ready && !clear;
    assign pop     = tick && !loop_q && (level != '0);
    assign emit    = tick && (loop_q || (level != '0));
    assign uf_set  = loop_rej || (tick && !loop_q && (level == '0));
    assign rd_addr = loop_q ? rd_ptr + idx : rd_ptr;

    always_ff @(posedge vectorclk) begin
        if (wr) begin
            for (int i = 0; i < RATIO; i++) begin
                mem[wr_ptr + ptr_t'(i)] <= host.in_data[i*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge vectorclk or posedge vectorreset) begin
        if (vectorreset) begin
            state_q       <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            idx           <= '0;
            div_q         <= '0;
            rate_q        <= '0;
            loop_q        <= 1'b0;
            level         <= '0;
            underflow     <= 1'b0;
            vector_out    <= '0;
            vector_strobe <= 1'b0;
        end else if (clear) begin
            state_q       <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            idx           <= '0;
            div_q         <= '0;
            level         <= '0;
            underflow     <= 1'b0;
            vector_strobe <= 1'b0;
        end else begin
            state_q       <= state_d;
            vector_strobe <= emit;
            if (emit) vector_out <= mem[rd_addr];
            if (wr)   wr_ptr     <= wr_ptr + ptr_t'(RATIO);
            if (pop)  rd_ptr     <= rd_ptr + ptr_t'(1);
            level <= level + (wr ? lvl_t'(RATIO) : '0)
                           - (pop ? lvl_t'(1) : '0);
            if (uf_set) underflow <= 1'b1;
            if (start_ok) begin
                loop_q <= loop_mode;
                rate_q <= rate;
                div_q  <= '0;
                idx    <= '0;
            end else if (state_q == RUN) begin
                div_q <= tick ? '0 : div_q + 1'b1;
            end
            // level is frozen during a loop run, so it is the pattern length
            if (emit && loop_q) begin
                idx <= ({1'b0, idx} == level - lvl_t'(1)) ? '0 : idx + ptr_t'(1);
            end
        end
    end

`ifdef BIOEE_VECTOR_PROG_FULL_EN
    always_ff @(posedge vectorclk or posedge vectorreset) begin
        if (vectorreset) prog_full <= 1'b0;
        else             prog_full <= (level >= prog_full_thresh);
    end
`endif

endmodule

// File: tb/tb_bioee_vector_player.sv
// Self-checking bench for bioee_vector_player (DEPTH_LOG2=4, 32->16 bits).
// Directed table, corner sequences and a randomized queue-model run.
module tb_bioee_vector_player;
    localparam int IN_W = 32, OUT_W = 16, DL = 4, DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 0, start = 0, stop = 0, loop_mode = 0;
    logic [DIV_W-1:0] rate = '0;
    logic [OUT_W-1:0] vector_out;
    logic             vector_strobe, busy, underflow;
    logic [DL:0]      level;
`ifdef BIOEE_VECTOR_PROG_FULL_EN
    logic [DL:0]      pft = 5'd4;
    logic             prog_full;
`endif

    bioee_vector_player_if #(.IN_W(IN_W)) hif ();

    bioee_vector_player #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH_LOG2(DL), .DIV_W(DIV_W)
    ) dut (
        .vectorclk(clk), .vectorreset(rst), .host(hif.slave),
        .clear(clear), .start(start), .stop(stop), .loop_mode(loop_mode),
        .rate(rate), .vector_out(vector_out), .vector_strobe(vector_strobe),
        .busy(busy), .level(level), .underflow(underflow)
`ifdef BIOEE_VECTOR_PROG_FULL_EN
        , .prog_full_thresh(pft), .prog_full(prog_full)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        hif.in_valid = 0; hif.in_data = '0;
        clear = 0; start = 0; stop = 0; loop_mode = 0; rate = '0;
    endtask

    task automatic do_clear();
        idle_in(); clear = 1; step(); clear = 0;
    endtask

    task automatic wr_word(input logic [31:0] w);
        hif.in_valid = 1; hif.in_data = w; step(); hif.in_valid = 0;
    endtask

    typedef struct {
        logic vld; logic [31:0] dat; logic sta, stp, clr, lm; logic [15:0] rt;
        logic stb; logic [15:0] vo; logic vo_chk;
        logic [4:0] lvl; logic bsy, uf, rdy;
    } vec_t;
    vec_t tbl[15];

    logic [15:0] pat[6];
    logic [15:0] mq[$];
    logic        m_run, m_loop, m_stb, m_uf, m_rdy, m_tick;
    int          m_rate, m_cnt, m_idx, sz0;
    logic [15:0] m_out;
    logic        r_vld, r_sta, r_stp, r_clr, r_lm;
    logic [31:0] r_dat;
    int          r_rt;

    initial begin
        idle_in();
        #2;
        chk("rst_vo", vector_out, 0);
        chk("rst_stb", vector_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_lvl", level, 0);
        chk("rst_rdy", hif.in_ready, 1);
        step();
        rst = 0;
        step();

        tbl[0]  = '{0, 32'h0,        1,1,0,0,0, 0,16'h0,   0,0,0,0,1};
        tbl[1]  = '{1, 32'h22221111, 0,0,1,0,0, 0,16'h0,   0,0,0,0,1};
        tbl[2]  = '{0, 32'h0,        1,0,0,1,0, 0,16'h0,   0,0,0,1,1};
        tbl[3]  = '{0, 32'h0,        0,0,1,0,0, 0,16'h0,   0,0,0,0,1};
        tbl[4]  = '{1, 32'h22221111, 0,0,0,0,0, 0,16'h0,   0,2,0,0,1};
        tbl[5]  = '{1, 32'h44443333, 0,0,0,0,0, 0,16'h0,   0,4,0,0,1};
        tbl[6]  = '{0, 32'h0,        1,0,0,0,1, 0,16'h0,   0,4,1,0,1};
        tbl[7]  = '{0, 32'h0,        0,0,0,0,0, 0,16'h0,   0,4,1,0,1};
        tbl[8]  = '{0, 32'h0,        0,0,0,0,0, 1,16'h1111,1,3,1,0,1};
        tbl[9]  = '{0, 32'h0,        0,0,0,0,0, 0,16'h1111,1,3,1,0,1};
        tbl[10] = '{0, 32'h0,        0,0,0,0,0, 1,16'h2222,1,2,1,0,1};
        tbl[11] = '{0, 32'h0,        1,0,0,1,0, 0,16'h2222,1,2,1,0,1};
        tbl[12] = '{1, 32'h66665555, 0,0,0,0,0, 1,16'h3333,1,3,1,0,1};
        tbl[13] = '{0, 32'h0,        0,1,0,0,0, 0,16'h3333,1,3,0,0,1};
        tbl[14] = '{0, 32'h0,        0,0,0,0,0, 0,16'h3333,1,3,0,0,1};
        for (int i = 0; i < 15; i++) begin
            hif.in_valid = tbl[i].vld; hif.in_data = tbl[i].dat;
            start = tbl[i].sta; stop = tbl[i].stp; clear = tbl[i].clr;
            loop_mode = tbl[i].lm; rate = tbl[i].rt;
            step();
            chk($sformatf("tbl%0d_stb", i), vector_strobe, tbl[i].stb);
            if (tbl[i].vo_chk) chk($sformatf("tbl%0d_vo", i), vector_out, tbl[i].vo);
            chk($sformatf("tbl%0d_lvl", i), level, tbl[i].lvl);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_uf", i), underflow, tbl[i].uf);
            chk($sformatf("tbl%0d_rdy", i), hif.in_ready, tbl[i].rdy);
        end
        idle_in();

        // stream, rate=3: strobes every 4 clocks, then underflow
        do_clear();
        wr_word(32'h22221111);
        wr_word(32'h44443333);
        start = 1; rate = 3; step(); idle_in();
        for (int k = 1; k <= 21; k++) begin
            step();
            chk($sformatf("s3_stb%0d", k), vector_strobe, (k % 4 == 0) && (k <= 16));
            if ((k % 4 == 0) && (k <= 16))
                chk($sformatf("s3_vo%0d", k), vector_out, 16'h1111 * (k / 4));
            chk($sformatf("s3_uf%0d", k), underflow, k >= 20);
        end
        chk("s3_vo_hold", vector_out, 16'h4444);

        // loop, rate=0: six-vector pattern repeats every cycle
        do_clear();
        pat = '{16'h1a1a, 16'h2b2b, 16'h3c3c, 16'h4d4d, 16'h5e5e, 16'h6f6f};
        for (int w = 0; w < 3; w++) wr_word({pat[2*w+1], pat[2*w]});
        start = 1; loop_mode = 1; step(); idle_in();
        hif.in_valid = 1; hif.in_data = 32'hdeadbeef;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("lp_stb%0d", k), vector_strobe, 1);
            chk($sformatf("lp_vo%0d", k), vector_out, pat[(k-1) % 6]);
            chk($sformatf("lp_rdy%0d", k), hif.in_ready, 0);
            chk($sformatf("lp_lvl%0d", k), level, 6);
        end
        hif.in_valid = 0; stop = 1; step(); stop = 0;
        chk("lp_stop_stb", vector_strobe, 0);
        chk("lp_stop_busy", busy, 0);
        step();
        chk("lp_after_stb", vector_strobe, 0);
        chk("lp_after_lvl", level, 6);

        // fill a 16-deep buffer
        do_clear();
        for (int w = 0; w < 8; w++) wr_word(32'h00010000 * (2*w+1) + (2*w));
        chk("fill_lvl", level, 16);
        chk("fill_rdy", hif.in_ready, 0);
        wr_word(32'hffffffff);
        chk("fill_9th_lvl", level, 16);
        start = 1; step(); start = 0;
        step();
        chk("fill_pop_lvl", level, 15);
        chk("fill_pop_vo", vector_out, 0);
        chk("fill_pop_rdy", hif.in_ready, 0);
        stop = 1; step(); stop = 0;
        chk("fill_stop_lvl", level, 15);
        chk("fill_stop_rdy", hif.in_ready, 0);

`ifdef BIOEE_VECTOR_PROG_FULL_EN
        do_clear();
        pft = 5'd4;
        wr_word(32'h00020001);
        chk("pf_lvl2", prog_full, 0);
        wr_word(32'h00040003);
        chk("pf_lag", prog_full, 0);
        step();
        chk("pf_rise", prog_full, 1);
        start = 1; step(); start = 0;
        step();
        chk("pf_pop1", prog_full, 1);
        step();
        chk("pf_fall", prog_full, 0);
        stop = 1; step(); stop = 0;
`endif

        // reset in the middle of a stream run
        do_clear();
        for (int w = 0; w < 4; w++) wr_word(32'h0bad0000 + w);
        start = 1; step(); start = 0;
        step();
        chk("mr_running", vector_strobe, 1);
        rst = 1; #1;
        chk("mr_vo", vector_out, 0);
        chk("mr_stb", vector_strobe, 0);
        chk("mr_busy", busy, 0);
        chk("mr_lvl", level, 0);
        chk("mr_uf", underflow, 0);
        chk("mr_rdy", hif.in_ready, 1);
        #1 rst = 0;
        start = 1; step(); start = 0;
        step();
        chk("mr_nostb", vector_strobe, 0);
        chk("mr_uf_set", underflow, 1);
        chk("mr_busy_run", busy, 1);

        // randomized run against a queue model
        rst = 1; step(); rst = 0; idle_in();
        mq.delete();
        m_run = 0; m_loop = 0; m_stb = 0; m_uf = 0; m_out = '0;
        m_rate = 0; m_cnt = 0; m_idx = 0;
        for (int c = 0; c < 800; c++) begin
            m_rdy = (16 - mq.size() >= 2) && !(m_run && m_loop);
            chk("rnd_rdy", hif.in_ready, m_rdy);
            r_vld = ($urandom_range(1) == 1);
            r_dat = $urandom;
            r_sta = ($urandom_range(9) == 0);
            r_stp = ($urandom_range(29) == 0);
            r_clr = ($urandom_range(59) == 0);
            r_lm  = ($urandom_range(1) == 1);
            r_rt  = $urandom_range(3);
            hif.in_valid = r_vld; hif.in_data = r_dat;
            start = r_sta; stop = r_stp; clear = r_clr;
            loop_mode = r_lm; rate = DIV_W'(r_rt);
            step();
            if (r_clr) begin
                mq.delete(); m_run = 0; m_uf = 0; m_stb = 0;
            end else begin
                m_tick = m_run && !r_stp && (m_cnt == m_rate);
                m_stb = 0;
                sz0 = mq.size();
                if (m_tick) begin
                    if (m_loop) begin
                        m_out = mq[m_idx]; m_stb = 1;
                        m_idx = (m_idx + 1) % mq.size();
                    end else if (mq.size() > 0) begin
                        m_out = mq.pop_front(); m_stb = 1;
                    end else begin
                        m_uf = 1;
                    end
                end
                if (r_vld && m_rdy) begin
                    mq.push_back(r_dat[15:0]);
                    mq.push_back(r_dat[31:16]);
                end
                if (m_run) begin
                    if (r_stp) m_run = 0;
                    else m_cnt = m_tick ? 0 : m_cnt + 1;
                end else if (r_sta && !r_stp) begin
                    if (r_lm && sz0 == 0) m_uf = 1;
                    else begin
                        m_run = 1; m_loop = r_lm; m_rate = r_rt;
                        m_cnt = 0; m_idx = 0;
                    end
                end
            end
            chk("rnd_stb", vector_strobe, m_stb);
            chk("rnd_vo", vector_out, m_out);
            chk("rnd_lvl", level, mq.size());
            chk("rnd_busy", busy, m_run);
            chk("rnd_uf", underflow, m_uf);
        end
        idle_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bioee_vector_player.md
Name: bioee_vector_player

Overview:
- Parametrised successor to the PC-to-vector output path.
- Accepts IN_W-bit words from the host pipe, already in the vectorclk domain, and splits each into OUT_W-bit vectors, low slice first.
- Buffers the vectors and plays them out at a programmable rate.
- Two playback modes: stream (consume-once FIFO) and loop (repeat the loaded pattern). Adds run control, rate division, level reporting and underflow flagging.

Parameters:
- IN_W, 32: input word width; must be an integer multiple of OUT_W.
- OUT_W, 16: vector output width.
- DEPTH_LOG2, 10: buffer holds 2**DEPTH_LOG2 vectors of OUT_W bits.
- DIV_W, 16: width of the rate divider.
- RATIO (localparam): IN_W/OUT_W.

Ports:
- vectorclk  in  1  sole clock.
- vectorreset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_data  in  IN_W  input word; slice [OUT_W-1:0] plays first.
- in_ready  out  1  word accepted when in_valid && in_ready.
- clear  in  1  synchronous flush of buffer, pointers and state.
- start  in  1  one-cycle pulse: begin playback.
- stop  in  1  one-cycle pulse: end playback.
- loop_mode  in  1  0 = stream, 1 = loop; sampled only when start is accepted.
- rate  in  DIV_W  one vector every rate+1 clocks; sampled when start is accepted.
- vector_out  out  OUT_W  registered vector output.
- vector_strobe  out  1  high for the one cycle in which vector_out takes a new value.
- busy  out  1  state is RUN.
- level  out  DEPTH_LOG2+1  stored vectors, range 0..2**DEPTH_LOG2.
- underflow  out  1  sticky error flag.

Behaviour:
- Reset (async) values:
  - vector_out=0, vector_strobe=0, busy=0, underflow=0, level=0.
  - in_ready=1, FSM=IDLE, all pointers and divider = 0.
- Write side:
  - in_ready = (free slots >= RATIO) && !(busy && loop mode).
  - An accepted word writes RATIO consecutive slots at wr_ptr (low slice at the lowest slot); wr_ptr advances by RATIO, modulo depth.
  - No partial word is ever stored.
- FSM IDLE:
  - start accepted: latch loop_mode and rate, divider=0, rd index=rd_ptr, go to RUN.
  - Loop mode with level==0: start is rejected, underflow is set, FSM stays IDLE.
- FSM RUN:
  - The divider counts 0..rate. A tick occurs in the cycle where divider==rate; divider then returns to 0.
  - First tick is rate+1 cycles after start was accepted; rate=0 gives a tick every cycle.
  - Tick in stream mode with level>0: pop the slot at rd_ptr, rd_ptr+1 (wraps), level-1.
  - Tick in loop mode: output slot (rd_base+idx); idx wraps to 0 after level_at_start-1. Buffer is not consumed and level is unchanged.
  - Tick result is visible on the next edge: vector_out updates and vector_strobe=1 in the same cycle.
  - Tick in stream mode with level==0: no strobe, vector_out holds its value, underflow set, FSM stays RUN. Playback resumes on the next tick after new data arrives.
  - stop: go to IDLE on the next edge. vector_out holds, no further strobes. In stream mode unplayed data stays buffered; in loop mode the pattern is retained.
- Simultaneous events:
  - start and stop in the same cycle: stop wins.
  - start while already RUN: ignored.
  - Write and pop in the same cycle: level = level + RATIO - 1.
  - A write that arrives while level==0 and a tick falls in the same cycle does not satisfy that tick: underflow.
  - clear in any state: FSM=IDLE, level=0, pointers=0, underflow=0. vector_out holds. clear beats start and writes in the same cycle.
- underflow clears only on clear or reset.

Optional Feature:
- Macro: BIOEE_VECTOR_PROG_FULL_EN.
- When defined, adds two ports:
  - input prog_full_thresh [DEPTH_LOG2:0].
  - output prog_full, registered, = (level >= prog_full_thresh), reset value 0, updated one cycle after level changes.
- When undefined, neither port exists and there is no related logic.

Test Plan:
- Reset mid-RUN (stream, rate=0, 8 vectors queued): assert vectorreset for 1 cycle -> all outputs return to reset values asynchronously; level=0; a following start runs with no strobes and underflow=1.
- Stream, rate=3: write 0x22221111, 0x44443333, then start -> vectors 0x1111, 0x2222, 0x3333, 0x4444 on strobes 4 clocks apart, first strobe 5 cycles after start; then underflow=1, vector_out stays 0x4444.
- Loop, rate=0: load 3 words (6 vectors A..F), start -> A..F repeating every cycle for 20 cycles, in_ready=0, level=6 throughout; stop -> strobes cease, level=6.
- Fill: DEPTH_LOG2=4, write 8 words -> level=16, in_ready=0; the 9th in_valid is not accepted; one stream pop at rate=0 leaves in_ready=0 until free>=2.
- Simultaneous events: start+stop same cycle -> busy stays 0; clear+in_valid same cycle -> level=0; loop start with empty buffer -> underflow=1, busy=0.
- With BIOEE_VECTOR_PROG_FULL_EN defined and prog_full_thresh=4: write 2 words -> prog_full rises one cycle after level reaches 4, and falls after the first pop.
